// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle ARM-subset controller.
//   - state_t        : controller sequencing states
//   - alu_op_t       : ALUControl encodings
//   - CMD_* / COND_* : data-processing command and condition-field codes
//   - RES_* / SRCB_* : ResultSrc and ALUSrcB mux encodings
//   - OP_*           : Instr[27:26] instruction class
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    FAULT  = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || (cmd == CMD_CMP);
  endfunction

  // Unsupported commands fall back to ADD; CMP is a SUB with no writeback.
  function automatic alu_op_t cmd_to_alu(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB: return ALU_SUB;
      CMD_CMP: return ALU_SUB;
      CMD_AND: return ALU_AND;
      CMD_ORR: return ALU_ORR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_cond_check.sv
// cond_check: combinational ARM condition evaluation.
//   cond    in  4  Instr[31:28]
//   flags   in  4  {N,Z,C,V}
//   cond_ex out 1  1 when the instruction should take architectural effect
// The 4'b1111 code (unconditional space) is treated as never-execute.
module cond_check
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle ARM-subset control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WRITEBACK, owns the NZCV register and
// gates every architectural write with the condition check.
// Ports:
//   clk, reset (async, active-low), Instr[31:0], ALUFlags[3:0] {N,Z,C,V}
//   enables : PC_src, RF_en, D_en, IRWrite (forced low while reset is low)
//   selects : AdrSrc, ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0], ALUControl[1:0],
//             ImmSrc[1:0], RegSrc[1:0]
//   Flags[3:0] : current NZCV register
//   illegal    : only with MC_CTRL_ILLEGAL_TRAP_EN; high while in FAULT
// Build option MC_CTRL_ILLEGAL_TRAP_EN: op=11 or an unsupported data-processing
// command traps into FAULT, which only reset leaves. Without it op=11 is a NOP
// and unsupported commands execute as ADD.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PC_src,
  output logic        RF_en,
  output logic        D_en,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic [3:0]  Flags
);

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       s_bit, is_cmp, rd_pc, cmd_ok;
  logic       cond_ex;
  logic       pc_we, rf_we, d_we, ir_we;
  logic       unused_instr_bits;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  assign cond   = Instr[31:28];
  assign op     = Instr[27:26];
  assign funct  = Instr[25:20];
  assign rd     = Instr[15:12];
  assign cmd    = funct[4:1];
  assign s_bit  = funct[0];
  assign is_cmp = (cmd == CMD_CMP);
  assign rd_pc  = (rd == 4'hF);
  assign cmd_ok = cmd_supported(cmd);
  assign unused_instr_bits = ^{Instr[19:16], Instr[11:0], cmd_ok};

  assign Flags  = flags_q;
  assign ImmSrc = op;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_MEM: state_d = MEMADR;
          OP_BR:  state_d = BRANCH;
          OP_DP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (!cmd_ok) state_d = FAULT;
            else
`endif
            state_d = funct[5] ? EXECI : EXECR;
          end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default: state_d = FAULT;
`else
          default: state_d = FETCH;
`endif
        endcase
      end
      MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      FAULT:  state_d = FAULT;
`endif
      default: state_d = FETCH;
    endcase
  end

  // Flag write happens at the edge that ends EXEC. The condition verdict is
  // snapshotted at the same edge so ALUWB is gated by the pre-update flags
  // (e.g. ADDSNE that sets Z must still write its result).
  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    if (state_q == EXECR || state_q == EXECI) begin
      cond_ex_d = cond_ex;
      if (cond_ex && (s_bit || is_cmp)) begin
        flags_d[3:2] = ALUFlags[3:2];
        if (cmd == CMD_ADD || cmd == CMD_SUB || is_cmp)
          flags_d[1:0] = ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    d_we       = 1'b0;
    ir_we      = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    ALUControl = ALU_ADD;
    RegSrc     = 2'b00;
    case (state_q)
      FETCH: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        RegSrc[1] = (op == OP_BR);
      end
      MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
        RegSrc[0]  = ~funct[0];
      end
      MEMRD: AdrSrc = 1'b1;
      MEMWR: begin
        AdrSrc = 1'b1;
        d_we   = cond_ex;
      end
      MEMWB: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_DATA;
        rf_we     = cond_ex;
        pc_we     = cond_ex & rd_pc;
      end
      EXECR: ALUControl = cmd_to_alu(cmd);
      EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = cmd_to_alu(cmd);
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        rf_we     = cond_ex_q & ~is_cmp;
        pc_we     = cond_ex_q & rd_pc & ~is_cmp;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        pc_we     = cond_ex;
      end
      default: ;
    endcase
  end

  // Enables are masked by the reset pin itself so they drop the instant reset
  // asserts, not at the next clock edge.
  assign PC_src  = pc_we & reset;
  assign RF_en   = rf_we & reset;
  assign D_en    = d_we  & reset;
  assign IRWrite = ir_we & reset;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state_q == FAULT);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      flags_q   <= RESET_FLAGS;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

endmodule
